// File: rtl/bht_assoc.sv
// -----------------------------------------------------------------------------
// bht_assoc : set-associative branch history table / branch target buffer
//
// Each entry holds a valid bit, a tag, a branch target and a 2-bit saturating
// direction counter. Fetch looks up the current PC combinationally and gets a
// predicted next PC in the same cycle. Execute writes back one resolved branch
// per cycle. When a set is full, round-robin replacement picks the victim.
//
// Parameters
//   ADDR_W   instruction byte-address width
//   INDEX_W  set index bits (SETS = 2**INDEX_W)
//   WAYS     ways per set (1, 2 or 4)
//
// Ports
//   clk                   in   rising-edge clock
//   rst_n                 in   asynchronous active-low reset
//   flush                 in   synchronous invalidate of all entries
//   insert_ins_addr       in   PC of the resolved branch
//   insert_ins_next_addr  in   resolved branch target
//   is_branch             in   update strobe
//   is_suc                in   resolved direction, 1 = taken
//   query_ins_addr        in   fetch PC to predict
//   predict_addr          out  predicted next PC
//   predict_jump          out  predicted taken
//   predict_hit           out  query matched a valid entry
// -----------------------------------------------------------------------------
module bht_assoc #(
   parameter int ADDR_W  = 12,
   parameter int INDEX_W = 3,
   parameter int WAYS    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [ADDR_W-1:0] insert_ins_addr,
   input  logic [ADDR_W-1:0] insert_ins_next_addr,
   input  logic              is_branch,
   input  logic              is_suc,
   input  logic [ADDR_W-1:0] query_ins_addr,
   output logic [ADDR_W-1:0] predict_addr,
   output logic              predict_jump,
   output logic              predict_hit
);

   localparam int SETS  = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W - 2;
   localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic              r_valid  [SETS][WAYS];
   logic [TAG_W-1:0]  r_tag    [SETS][WAYS];
   logic [ADDR_W-1:0] r_target [SETS][WAYS];
   logic [1:0]        r_ctr    [SETS][WAYS];
   logic [RR_W-1:0]   r_rr     [SETS];

   // Saturating 2-bit direction counter step.
   function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
      if (up)
         sat_ctr = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      else
         sat_ctr = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
   endfunction

   // Query lookup. Reads only registered state, so a same-cycle update is
   // not visible until the following cycle.
   logic [INDEX_W-1:0] w_q_idx;
   logic [TAG_W-1:0]   w_q_tag;
   logic               w_q_hit;
   logic [1:0]         w_q_ctr;
   logic [ADDR_W-1:0]  w_q_target;

   always_comb begin
      w_q_idx    = query_ins_addr[INDEX_W+1:2];
      w_q_tag    = query_ins_addr[ADDR_W-1:INDEX_W+2];
      w_q_hit    = 1'b0;
      w_q_ctr    = 2'b00;
      w_q_target = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_q_idx][w] && (r_tag[w_q_idx][w] == w_q_tag)) begin
            w_q_hit    = 1'b1;
            w_q_ctr    = r_ctr[w_q_idx][w];
            w_q_target = r_target[w_q_idx][w];
         end
      end
   end

   assign predict_hit  = w_q_hit;
   assign predict_jump = w_q_hit & w_q_ctr[1];
   assign predict_addr = (w_q_hit && w_q_ctr[1]) ? w_q_target
                                                  : query_ins_addr + ADDR_W'(4);

   // Update way selection: the matching way on a hit, otherwise the lowest
   // invalid way, otherwise the set's round-robin victim.
   logic [INDEX_W-1:0] w_u_idx;
   logic [TAG_W-1:0]   w_u_tag;
   logic               w_u_hit;
   logic [RR_W-1:0]    w_u_hit_way;
   logic               w_inv_found;
   logic [RR_W-1:0]    w_inv_way;
   logic [RR_W-1:0]    w_u_way;

   always_comb begin
      w_u_idx     = insert_ins_addr[INDEX_W+1:2];
      w_u_tag     = insert_ins_addr[ADDR_W-1:INDEX_W+2];
      w_u_hit     = 1'b0;
      w_u_hit_way = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_u_idx][w] && (r_tag[w_u_idx][w] == w_u_tag)) begin
            w_u_hit     = 1'b1;
            w_u_hit_way = RR_W'(w);
         end
         if (!r_valid[w_u_idx][w] && !w_inv_found) begin
            w_inv_found = 1'b1;
            w_inv_way   = RR_W'(w);
         end
      end
      if (w_u_hit)
         w_u_way = w_u_hit_way;
      else if (w_inv_found)
         w_u_way = w_inv_way;
      else
         w_u_way = r_rr[w_u_idx];
   end

   // Table state. Flush takes priority over a same-cycle update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            r_rr[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               r_valid[s][w]  <= 1'b0;
               r_tag[s][w]    <= '0;
               r_target[s][w] <= '0;
               r_ctr[s][w]    <= 2'b00;
            end
         end
      end else if (flush) begin
         for (int s = 0; s < SETS; s++) begin
            r_rr[s] <= '0;
            for (int w = 0; w < WAYS; w++)
               r_valid[s][w] <= 1'b0;
         end
      end else if (is_branch) begin
         for (int w = 0; w < WAYS; w++) begin
            if (RR_W'(w) == w_u_way) begin
               if (w_u_hit) begin
                  r_ctr[w_u_idx][w] <= sat_ctr(r_ctr[w_u_idx][w], is_suc);
                  if (is_suc)
                     r_target[w_u_idx][w] <= insert_ins_next_addr;
               end else begin
                  r_valid[w_u_idx][w]  <= 1'b1;
                  r_tag[w_u_idx][w]    <= w_u_tag;
                  r_target[w_u_idx][w] <= insert_ins_next_addr;
                  r_ctr[w_u_idx][w]    <= is_suc ? 2'b10 : 2'b01;
               end
            end
         end
         // Pointer only advances when a live entry is displaced. With one way
         // the wrap compare keeps it pinned at zero.
         if (!w_u_hit && !w_inv_found)
            r_rr[w_u_idx] <= (r_rr[w_u_idx] == RR_W'(WAYS - 1)) ? '0
                                                                 : r_rr[w_u_idx] + RR_W'(1);
      end
   end

endmodule

// File: tb/tb_bht_assoc.sv
module tb_bht_assoc;

   localparam int ADDR_W  = 12;
   localparam int INDEX_W = 3;
   localparam int WAYS    = 2;
   localparam int SETS    = 1 << INDEX_W;
   localparam int AMOD    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic [ADDR_W-1:0] insert_ins_addr;
   logic [ADDR_W-1:0] insert_ins_next_addr;
   logic              is_branch;
   logic              is_suc;
   logic [ADDR_W-1:0] query_ins_addr;
   logic [ADDR_W-1:0] predict_addr;
   logic              predict_jump;
   logic              predict_hit;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bht_assoc #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .flush                (flush),
      .insert_ins_addr      (insert_ins_addr),
      .insert_ins_next_addr (insert_ins_next_addr),
      .is_branch            (is_branch),
      .is_suc               (is_suc),
      .query_ins_addr       (query_ins_addr),
      .predict_addr         (predict_addr),
      .predict_jump         (predict_jump),
      .predict_hit          (predict_hit)
   );

   // Reference model: per set, a small list of entries plus a victim pointer.
   bit m_valid [SETS][WAYS];
   int m_tag   [SETS][WAYS];
   int m_tgt   [SETS][WAYS];
   int m_ctr   [SETS][WAYS];
   int m_rr    [SETS];

   function automatic int set_of(input int a);
      return (a / 4) % SETS;
   endfunction

   function automatic int tag_of(input int a);
      return a / (4 * SETS);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0; m_ctr[s][w] = 0;
         end
      end
   endtask

   task automatic model_flush();
      for (int s = 0; s < SETS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
      end
   endtask

   task automatic model_query(input int a, output bit h, output bit j, output int pa);
      int s, t;
      s = set_of(a); t = tag_of(a);
      h = 0; j = 0; pa = (a + 4) % AMOD;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) begin
            h = 1;
            if (m_ctr[s][w] >= 2) begin j = 1; pa = m_tgt[s][w]; end
         end
   endtask

   task automatic model_update(input int pc, input int nxt, input bit suc);
      int s, t, way;
      s = set_of(pc); t = tag_of(pc); way = -1;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) way = w;
      if (way >= 0) begin
         if (suc) begin
            m_ctr[s][way] = (m_ctr[s][way] < 3) ? m_ctr[s][way] + 1 : 3;
            m_tgt[s][way] = nxt;
         end else begin
            m_ctr[s][way] = (m_ctr[s][way] > 0) ? m_ctr[s][way] - 1 : 0;
         end
         return;
      end
      for (int w = 0; w < WAYS && way < 0; w++)
         if (!m_valid[s][w]) way = w;
      if (way < 0) begin
         way = m_rr[s];
         m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      m_valid[s][way] = 1;
      m_tag[s][way]   = t;
      m_tgt[s][way]   = nxt;
      m_ctr[s][way]   = suc ? 2 : 1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Compare the DUT outputs for the currently driven query against the model.
   task automatic check_model(input string tag);
      bit h, j;
      int pa;
      model_query(int'(query_ins_addr), h, j, pa);
      chk({tag, "_hit"},  int'(predict_hit),  int'(h));
      chk({tag, "_jump"}, int'(predict_jump), int'(j));
      chk({tag, "_addr"}, int'(predict_addr), pa);
   endtask

   // One full clock: drive at the falling edge, check mid-phase, clock, realign.
   task automatic do_cycle(input string tag, input bit upd, input int pc, input int nxt,
                           input bit suc, input bit fl, input int q);
      is_branch            = upd;
      insert_ins_addr      = ADDR_W'(pc);
      insert_ins_next_addr = ADDR_W'(nxt);
      is_suc               = suc;
      flush                = fl;
      query_ins_addr       = ADDR_W'(q);
      #1;
      check_model(tag);
      @(posedge clk);
      if (fl) model_flush();
      else if (upd) model_update(pc, nxt, suc);
      @(negedge clk);
   endtask

   task automatic update(input int pc, input int nxt, input bit suc);
      do_cycle("upd", 1'b1, pc, nxt, suc, 1'b0, pc);
   endtask

   // Query without clocking; checks against the model and the given constants.
   task automatic probe(input string tag, input int q, input bit eh, input bit ej, input int ea);
      is_branch      = 1'b0;
      flush          = 1'b0;
      query_ins_addr = ADDR_W'(q);
      #1;
      check_model(tag);
      chk({tag, "_hit_c"},  int'(predict_hit),  int'(eh));
      chk({tag, "_jump_c"}, int'(predict_jump), int'(ej));
      chk({tag, "_addr_c"}, int'(predict_addr), ea);
   endtask

   task automatic hard_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; is_branch = 1'b0; is_suc = 1'b0;
      insert_ins_addr = '0; insert_ins_next_addr = '0; query_ins_addr = '0;
      model_reset();
      repeat (2) @(negedge clk);

      // Query during reset reads as a miss.
      probe("rst_during", 4, 0, 0, 8);
      rst_n = 1'b1;

      // 1: empty table
      probe("t1", 4, 0, 0, 8);
      probe("wrap", 12'hFFC, 0, 0, 0);

      // 2/3: counter and target behaviour on a single entry
      update(4, 12, 1);
      probe("t2", 4, 1, 1, 12);
      update(4, 16, 1);
      probe("t3_ctr11", 4, 1, 1, 16);
      update(4, 20, 1);
      update(4, 24, 0);
      update(4, 28, 0);
      probe("t3_sat11", 4, 1, 0, 8);
      update(4, 28, 0);
      update(4, 28, 0);
      update(4, 28, 1);
      probe("t3_sat00", 4, 1, 0, 8);
      update(4, 32, 1);
      probe("t3_back10", 4, 1, 1, 32);

      // 4: round-robin replacement in set 2
      hard_reset();
      update(8, 100, 1);
      update(40, 200, 1);
      update(72, 300, 1);
      probe("t4_q8", 8, 0, 0, 12);
      probe("t4_q40", 40, 1, 1, 200);
      probe("t4_q72", 72, 1, 1, 300);
      update(104, 400, 1);
      probe("t4_q40b", 40, 0, 0, 44);
      probe("t4_q72b", 72, 1, 1, 300);
      probe("t4_q104", 104, 1, 1, 400);

      // 5: no same-cycle bypass, and flush beats update
      hard_reset();
      do_cycle("t5_same", 1'b1, 4, 60, 1'b1, 1'b0, 4);
      chk("t5_same_miss", int'(predict_hit), 1);
      probe("t5_next", 4, 1, 1, 60);
      do_cycle("t5_flush", 1'b1, 8, 64, 1'b1, 1'b1, 8);
      probe("t5_q4", 4, 0, 0, 8);
      probe("t5_q8", 8, 0, 0, 12);
      update(8, 64, 1);
      probe("t5_alloc_after", 8, 1, 1, 64);

      // 6: asynchronous reset between edges
      update(4, 500, 1);
      update(36, 504, 1);
      update(12, 508, 1);
      update(16, 512, 1);
      probe("t6_pre", 4, 1, 1, 500);
      rst_n = 1'b0;
      #1;
      chk("t6_async_hit", int'(predict_hit), 0);
      chk("t6_async_addr", int'(predict_addr), 8);
      model_reset();
      rst_n = 1'b1;
      @(negedge clk);
      probe("t6_q4", 4, 0, 0, 8);
      probe("t6_q36", 36, 0, 0, 40);
      probe("t6_q12", 12, 0, 0, 16);
      probe("t6_q16", 16, 0, 0, 20);

      // Randomized traffic: few tags per set so hits, evictions and saturation occur.
      for (int i = 0; i < 600; i++) begin
         int pc, q, nxt;
         bit upd, suc, fl;
         pc  = int'($urandom_range(0, 5)) * 32 + int'($urandom_range(0, 7)) * 4;
         q   = ($urandom_range(0, 3) == 0) ? pc
                                           : int'($urandom_range(0, 5)) * 32 + int'($urandom_range(0, 7)) * 4;
         nxt = int'($urandom_range(0, AMOD / 4 - 1)) * 4;
         upd = ($urandom_range(0, 3) != 0);
         suc = $urandom_range(0, 1) == 1;
         fl  = ($urandom_range(0, 49) == 0);
         do_cycle("rnd", upd, pc, nxt, suc, fl, q);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
